// File: rtl/dac_pkg.sv
// Shared definitions for the DAC SPI transmitter: FSM encoding, frame layout
// and a helper that assembles the 16-bit command word.
package dac_pkg;

   localparam int unsigned FRAME_W          = 16;
   localparam int unsigned SAMPLE_W         = 12;
   localparam int unsigned BIT_CNT_W        = 4;
   localparam int unsigned FRAME_CH_BIT     = 15;
   localparam int unsigned FRAME_BUF_BIT    = 14;
   localparam int unsigned FRAME_GA_N_BIT   = 13;
   localparam int unsigned FRAME_ACTIVE_BIT = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2,
      ST_LATCH = 2'd3
   } dac_state_e;

   function automatic logic [FRAME_W-1:0] build_frame(
      input logic                cfg_buf,
      input logic                cfg_ga_n,
      input logic [SAMPLE_W-1:0] sample
   );
      logic [FRAME_W-1:0] frame;
      frame                   = '0;
      frame[SAMPLE_W-1:0]     = sample;
      frame[FRAME_ACTIVE_BIT] = 1'b1;
      frame[FRAME_GA_N_BIT]   = cfg_ga_n;
      frame[FRAME_BUF_BIT]    = cfg_buf;
      frame[FRAME_CH_BIT]     = 1'b0;
      return frame;
   endfunction

endpackage

// File: rtl/dac_sck_tick.sv
// Divider producing a one-clk tick every CLK_DIV clocks; clear_i restarts
// the count so the first tick lands exactly CLK_DIV clocks later.
module dac_sck_tick #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   output logic tick_o
);

   localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 8'd1;
      if (clear_i || tick_o) cnt_d = '0;
   end

   // NOTE: non-blocking (<=) for every state register so all flops update
   // together from pre-edge values; reset here is synchronous to clk.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/dac_spi_tx.sv
// SPI transmitter for a 12-bit DAC: frames one sample MSB first, then pulses
// LDAC. A single pending slot absorbs samples arriving mid-frame.
module dac_spi_tx
   import dac_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 4,
   parameter bit          CFG_BUF  = 1'b0,
   parameter bit          CFG_GA_N = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] inSample,
   input  logic                inSampleReady,
   output logic                dacCs,
   output logic                dacSck,
   output logic                dacSdi,
   output logic                dacLdac,
   output logic                busy,
   output logic                sampleDropped
);

   localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_W - 1);

   dac_state_e            state_q, state_d;
   logic [FRAME_W-1:0]    shift_q, shift_d;
   logic [BIT_CNT_W-1:0]  bit_q, bit_d;
   logic                  sck_q, sck_d;
   logic                  cs_q, cs_d;
   logic                  ldac_q, ldac_d;
   logic                  busy_q, busy_d;
   logic                  drop_q, drop_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [SAMPLE_W-1:0]   pend_data_q, pend_data_d;
   logic                  tick;
   logic                  tick_clear;

   dac_sck_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .clear_i (tick_clear),
      .tick_o  (tick)
   );

   // NOTE: every signal gets its hold value first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_d        = bit_q;
      sck_d        = sck_q;
      cs_d         = cs_q;
      ldac_d       = ldac_q;
      busy_d       = busy_q;
      drop_d       = 1'b0;
      pend_valid_d = pend_valid_q;
      pend_data_d  = pend_data_q;
      tick_clear   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            tick_clear = 1'b1;
            busy_d     = 1'b0;
            cs_d       = 1'b1;
            // Pending is older than a same-cycle strobe, so it goes first and
            // the strobe takes its slot without counting as a drop.
            if (pend_valid_q || inSampleReady) begin
               if (pend_valid_q) begin
                  shift_d      = build_frame(CFG_BUF, CFG_GA_N, pend_data_q);
                  pend_valid_d = inSampleReady;
                  if (inSampleReady) pend_data_d = inSample;
               end else begin
                  shift_d = build_frame(CFG_BUF, CFG_GA_N, inSample);
               end
               state_d = ST_SHIFT;
               cs_d    = 1'b0;
               busy_d  = 1'b1;
               sck_d   = 1'b0;
               bit_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (tick) begin
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else begin
                  sck_d   = 1'b0;
                  shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                  if (bit_q == BIT_LAST) state_d = ST_HOLD;
                  else                   bit_d   = bit_q + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (tick) begin
               cs_d    = 1'b1;
               state_d = ST_LATCH;
            end
         end
         ST_LATCH: begin
            // First tick ends the CS-high gap, second ends the LDAC pulse.
            if (tick) begin
               if (ldac_q) begin
                  ldac_d = 1'b0;
               end else begin
                  ldac_d  = 1'b1;
                  busy_d  = 1'b0;
                  bit_d   = '0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_q != ST_IDLE && inSampleReady) begin
         pend_valid_d = 1'b1;
         pend_data_d  = inSample;
         drop_d       = pend_valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         bit_q        <= '0;
         sck_q        <= 1'b0;
         cs_q         <= 1'b1;
         ldac_q       <= 1'b1;
         busy_q       <= 1'b0;
         drop_q       <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_q        <= bit_d;
         sck_q        <= sck_d;
         cs_q         <= cs_d;
         ldac_q       <= ldac_d;
         busy_q       <= busy_d;
         drop_q       <= drop_d;
         pend_valid_q <= pend_valid_d;
         pend_data_q  <= pend_data_d;
      end
   end

   assign dacCs         = cs_q;
   assign dacSck        = sck_q;
   assign dacSdi        = shift_q[FRAME_W-1];
   assign dacLdac       = ldac_q;
   assign busy          = busy_q;
   assign sampleDropped = drop_q;

endmodule
